// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter_pkg
// Description : Shared FSM encoding, requester count and width defaults for
//               the two-port data-memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  localparam int NUM_REQ        = 2;
  localparam int ADDR_W_DEFAULT = 32;
  localparam int DATA_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // A word access is misaligned when either low byte-address bit is set.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick
// Description : Two-way round-robin winner selection (combinational).
//               A lone requester always wins; on a tie the requester that
//               was not granted last wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import dmem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last,
  output logic               winner,
  output logic               valid
);

  // Tie goes to the requester opposite the last grant.
  always_comb begin
    valid  = |req;
    winner = 1'b0;
    if (req == 2'b11) winner = ~last;
    else              winner = req[1];
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Arbitrates two requesters onto one data memory with a
//               synchronous-write / combinational-read port. Three-state
//               FSM (IDLE -> ACCESS -> RESP) gives one access per 3 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  state_t              state_q, state_d;
  logic                last_q;
  logic                win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                err_q;
  logic                pick_win;
  logic                pick_valid;

  rr_pick u_rr_pick (
    .req    ({req1, req0}),
    .last   (last_q),
    .winner (pick_win),
    .valid  (pick_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Request latch, grant pointer and response registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == ST_IDLE && pick_valid) begin
        last_q  <= pick_win;
        win_q   <= pick_win;
        we_q    <= pick_win ? we1    : we0;
        addr_q  <= pick_win ? addr1  : addr0;
        wdata_q <= pick_win ? wdata1 : wdata0;
      end
      if (state_q == ST_ACCESS) begin
        if (!we_q) rdata_q <= mem_dout;
        err_q <= is_misaligned(addr_q[1:0]);
      end
    end
  end

  // Next state and all outputs; every output is forced low during reset,
  // which also keeps the memory from being written on a reset edge.
  always_comb begin
    state_d  = state_q;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    rvalid0  = 1'b0;
    rvalid1  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    rdata    = rst_n ? rdata_q : '0;
    err      = rst_n & err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (rst_n) begin
          gnt0     = ~win_q;
          gnt1     = win_q;
          mem_we   = we_q;
          mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
          mem_din  = wdata_q;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
        if (rst_n) begin
          rvalid0 = ~win_q;
          rvalid1 = win_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a small
//               word-addressed data memory (sync write, comb read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic              gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
  logic [DATA_W-1:0] rdata, mem_din, mem_dout;
  logic [ADDR_W-1:0] mem_addr;

  logic [DATA_W-1:0] mem [0:63];

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  // Data memory: synchronous write, combinational read.
  always @(posedge clk) if (mem_we) mem[mem_addr[7:2]] <= mem_din;
  assign mem_dout = mem[mem_addr[7:2]];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .err(err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0] outs_or;
  int         ngnt;
  int         gnt_cyc [0:7];
  logic       gnt_who [0:7];

  initial begin
    rst_n = 1'b0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

    // Reset state
    step(); step();
    check("rst_gnt",    {gnt1, gnt0}, 2'b00);
    check("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
    check("rst_rdata",  rdata, 0);
    check("rst_err",    err, 0);
    check("rst_mem",    {mem_we, mem_addr, mem_din}, 0);
    rst_n = 1'b1;
    step();

    // Single write: req0, addr 8, 0xDEADBEEF
    req0 = 1; we0 = 1; addr0 = 32'd8; wdata0 = 32'hDEADBEEF;
    step();
    check("wr_gnt",     {gnt1, gnt0}, 2'b01);
    check("wr_mem_we",  mem_we, 1);
    check("wr_mem_addr", mem_addr, 8);
    check("wr_mem_din", mem_din, 32'hDEADBEEF);
    req0 = 0;
    step();
    check("wr_rvalid",  {rvalid1, rvalid0}, 2'b01);
    check("wr_err",     err, 0);
    check("wr_we_off",  {mem_we, gnt1, gnt0}, 3'b000);
    check("wr_word8",   mem[2], 32'hDEADBEEF);
    step();
    check("wr_idle",    {rvalid1, rvalid0}, 2'b00);

    // Read-back through requester 1
    req1 = 1; we1 = 0; addr1 = 32'd8;
    step();
    check("rd_gnt",     {gnt1, gnt0, mem_we}, 3'b100);
    req1 = 0;
    step();
    check("rd_rvalid",  {rvalid1, rvalid0}, 2'b10);
    check("rd_rdata",   rdata, 32'hDEADBEEF);
    step();

    // Misaligned write: addr 13 -> word 12
    req0 = 1; we0 = 1; addr0 = 32'd13; wdata0 = 32'h11;
    step();
    check("mis_gnt",    {gnt1, gnt0}, 2'b01);
    check("mis_addr",   mem_addr, 12);
    req0 = 0;
    step();
    check("mis_rvalid", {rvalid1, rvalid0}, 2'b01);
    check("mis_err",    err, 1);
    check("mis_word12", mem[3], 32'h11);
    check("mis_rdata_hold", rdata, 32'hDEADBEEF);
    step();

    // Seed word 4, then reset during a write of 0x55 to it
    req1 = 1; we1 = 1; addr1 = 32'd4; wdata1 = 32'h1234;
    step(); req1 = 0; step(); step();
    check("seed_word4", mem[1], 32'h1234);
    req0 = 1; we0 = 1; addr0 = 32'd4; wdata0 = 32'h55;
    step();
    check("rstw_gnt",   gnt0, 1);
    req0 = 0; rst_n = 1'b0;
    #1;
    check("rstw_we_gated", mem_we, 0);
    step();
    check("rstw_word4", mem[1], 32'h1234);
    check("rstw_outs",  {gnt1, gnt0, rvalid1, rvalid0, err, mem_we}, 0);
    check("rstw_data",  {rdata, mem_addr, mem_din}, 0);
    rst_n = 1'b1;
    step();
    check("rstw_no_rvalid", {rvalid1, rvalid0, gnt1, gnt0}, 0);
    check("rstw_idle_rdata", rdata, 0);

    // Contention: both held high, expect 0,1,0,1 every 3 cycles
    req0 = 1; we0 = 0; addr0 = 32'd8;
    req1 = 1; we1 = 0; addr1 = 32'd12;
    ngnt = 0;
    for (int c = 0; c < 12; c++) begin
      step();
      check("both_gnt_onehot", {31'd0, gnt0 & gnt1}, 0);
      if (gnt0 | gnt1) begin
        if (ngnt < 8) begin
          gnt_cyc[ngnt] = c;
          gnt_who[ngnt] = gnt1;
        end
        ngnt++;
      end
    end
    req0 = 0; req1 = 0;
    check("cont_count", ngnt, 4);
    for (int k = 0; k < 4 && k < ngnt; k++) begin
      check($sformatf("cont_who%0d", k), gnt_who[k], k[0]);
      check($sformatf("cont_cyc%0d", k), gnt_cyc[k], 3 * k);
    end
    step(); step(); step();

    // Idle: 10 cycles without requests
    outs_or = 2'b00;
    for (int c = 0; c < 10; c++) begin
      step();
      outs_or[0] = outs_or[0] | mem_we | gnt0 | gnt1;
      outs_or[1] = outs_or[1] | rvalid0 | rvalid1;
    end
    check("idle_quiet", outs_or, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, shall set the byte-address width.
REQ-002 Parameter DATA_W, default 32, shall set the data-word width.
REQ-003 Port clk, input, 1, shall be the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1, shall be the reset: synchronous and active-low.
REQ-005 Ports req0/req1, input, 1 each, shall request a memory access.
REQ-006 Ports we0/we1, input, 1 each, shall select write (1) or read (0).
REQ-007 Ports addr0/addr1, input, ADDR_W each, shall carry the byte address.
REQ-008 Ports wdata0/wdata1, input, DATA_W each, shall carry write data.
REQ-009 Ports gnt0/gnt1, output, 1 each, shall acknowledge acceptance of a request.
REQ-010 Ports rvalid0/rvalid1, output, 1 each, shall mark completion (read data or write done).
REQ-011 Port rdata, output, DATA_W, shall carry the registered read result shared by both requesters.
REQ-012 Port err, output, 1, shall flag a misaligned access, valid with rvalid.
REQ-013 Ports mem_addr (output, ADDR_W), mem_we (output, 1), mem_din (output, DATA_W), mem_dout (input, DATA_W) shall connect to data_memory: synchronous write, combinational read.

Function
REQ-014 FSM states shall be IDLE, ACCESS and RESP; RESP shall always return to IDLE.
REQ-015 IDLE: if any reqN=1, latch we/addr/wdata of the winner and the winner index, then go to ACCESS; otherwise stay in IDLE.
REQ-016 Arbitration shall be round-robin: a single requester always wins; if both request, the one not granted last wins; last-grant pointer updates on IDLE->ACCESS.
REQ-017 ACCESS: gntN=1 for the latched winner only; mem_addr = latched addr with bits [1:0] forced to 0; mem_din = latched wdata; mem_we = latched we.
REQ-018 ACCESS edge: rdata shall capture mem_dout for reads and hold its previous value for writes; err shall capture (latched addr[1:0] != 0).
REQ-019 RESP: rvalidN=1 for exactly one cycle to the latched winner.
REQ-020 Latency: req sampled in IDLE at cycle T gives gnt in T+1 and rvalid in T+2; peak throughput is one access per 3 cycles.
REQ-021 A requester shall hold req/we/addr/wdata stable until it sees gnt; a req still high in a later IDLE cycle is a new request.
REQ-022 Outside ACCESS: mem_we=0, gnt0=gnt1=0, mem_addr=0, mem_din=0.
REQ-023 Misaligned write: the aligned word shall still be written and err=1 reported.
REQ-024 With both requesters continuously requesting, grants shall alternate strictly 0,1,0,1,...
REQ-025 At most one of gnt0/gnt1 and at most one of rvalid0/rvalid1 shall be high in any cycle.

Reset
REQ-026 rst_n=0 at a rising edge shall force IDLE, last-grant pointer=1 (requester 0 wins first tie), rdata=0, err=0, all latches=0.
REQ-027 mem_we shall be gated by rst_n, so no memory write occurs on an edge where rst_n=0, even in ACCESS.
REQ-028 Reset in ACCESS or RESP shall drop the access with no rvalid; requesters re-request after release.
REQ-029 While rst_n=0 all outputs shall be 0.

Structure
REQ-030 A shared package shall hold the state encoding (IDLE=0, ACCESS=1, RESP=2), NUM_REQ=2, ADDR_W and DATA_W defaults.
REQ-031 One sub-module rr_pick shall take req vector and last pointer and produce winner index and valid (combinational).
REQ-032 The testbench shall instantiate dmem_arbiter with the existing data_memory.

Verification
REQ-033 Single write: req0, we0=1, addr0=8, wdata0=0xDEADBEEF at T -> gnt0 at T+1, mem_we=1 at T+1 only, rvalid0 at T+2, err=0.
REQ-034 Read-back: req1, we1=0, addr1=8 -> rvalid1 two cycles later with rdata=0xDEADBEEF.
REQ-035 Contention: req0 and req1 both held high after reset -> grant order 0,1,0,1; each gnt is 3 cycles after the previous one.
REQ-036 Misaligned: req0 write addr0=13, wdata0=0x11 -> word at 12 = 0x11, rvalid0 with err=1.
REQ-037 Reset mid-write: rst_n=0 during ACCESS of a write of 0x55 to addr 4 -> word 4 unchanged, no rvalid, state IDLE, outputs 0.
REQ-038 Idle: no req for 10 cycles -> mem_we, gnt and rvalid all stay 0.
